// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - TD4 step-enable generator; step counter built only when CPU_STEP_COUNT_EN is defined
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        quick_clock,
  input  logic        reset,
  input  logic        slow_tick_1hz,
  input  logic        slow_tick_10hz,
  input  logic [1:0]  mode,
  input  logic        step_button,
  output logic        cpu_enable,
  output logic [15:0] step_count
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_HALT     = 2'b00;
  localparam logic [1:0] ST_RUN_SLOW = 2'b01;
  localparam logic [1:0] ST_RUN_FAST = 2'b10;
  localparam logic [1:0] ST_MANUAL   = 2'b11;

  logic             t1_s1, t1_s2, t1_prev;
  logic             t10_s1, t10_s2, t10_prev;
  logic             btn_s1, btn_s2;
  logic [1:0]       mode_s1, mode_s2;
  logic             btn_state, btn_prev;
  logic [CNT_W-1:0] db_cnt;
  logic [1:0]       state;
  logic [1:0]       settle;
  logic             tick_1hz_edge, tick_10hz_edge, press_event;
  logic             sel_event, fire;

  // Two-flop synchronizers plus previous-value registers for tick edge detection
  always_ff @(posedge quick_clock) begin
    if (reset) begin
      t1_s1    <= 1'b0;
      t1_s2    <= 1'b0;
      t1_prev  <= 1'b0;
      t10_s1   <= 1'b0;
      t10_s2   <= 1'b0;
      t10_prev <= 1'b0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      mode_s1  <= 2'b00;
      mode_s2  <= 2'b00;
    end else begin
      t1_s1    <= slow_tick_1hz;
      t1_s2    <= t1_s1;
      t1_prev  <= t1_s2;
      t10_s1   <= slow_tick_10hz;
      t10_s2   <= t10_s1;
      t10_prev <= t10_s2;
      btn_s1   <= step_button;
      btn_s2   <= btn_s1;
      mode_s1  <= mode;
      mode_s2  <= mode_s1;
    end
  end

  // Debouncer: accept a new button level only after it holds for DEBOUNCE_CYCLES samples
  always_ff @(posedge quick_clock) begin
    if (reset) begin
      btn_state <= 1'b0;
      btn_prev  <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_prev <= btn_state;
      if (btn_s2 == btn_state) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_state <= btn_s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign tick_1hz_edge  = t1_s2 & ~t1_prev;
  assign tick_10hz_edge = t10_s2 & ~t10_prev;
  assign press_event    = btn_state & ~btn_prev;

  // Mode FSM: state simply follows the synchronized mode switch
  always_ff @(posedge quick_clock) begin
    if (reset) begin
      state <= ST_HALT;
    end else if (mode_s2 != state) begin
      state <= mode_s2;
    end
  end

  // Settle counter keeps the output quiet while the synchronizers refill after reset
  always_ff @(posedge quick_clock) begin
    if (reset) begin
      settle <= 2'd0;
    end else if (settle != 2'd3) begin
      settle <= settle + 2'd1;
    end
  end

  // Pick the event source that the current state listens to
  always_comb begin
    sel_event = 1'b0;
    case (state)
      ST_HALT:     sel_event = 1'b0;
      ST_RUN_SLOW: sel_event = tick_1hz_edge;
      ST_RUN_FAST: sel_event = tick_10hz_edge;
      ST_MANUAL:   sel_event = press_event;
      default:     sel_event = 1'b0;
    endcase
  end

  // A mode transition cycle drops whatever event happens to coincide with it
  assign fire = (settle == 2'd3) && (mode_s2 == state) && sel_event;

  // Registered single-cycle step pulse
  always_ff @(posedge quick_clock) begin
    if (reset) begin
      cpu_enable <= 1'b0;
    end else begin
      cpu_enable <= fire;
    end
  end

`ifdef CPU_STEP_COUNT_EN
  logic [15:0] step_count_q;

  // Free-running count of issued pulses, wrapping at 16 bits
  always_ff @(posedge quick_clock) begin
    if (reset) begin
      step_count_q <= 16'd0;
    end else if (fire) begin
      step_count_q <= step_count_q + 16'd1;
    end
  end

  assign step_count = step_count_q;
`else
  assign step_count = 16'd0;
`endif

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Step-enable generator between the prescalers and the TD4 core. Synchronizes the 1 Hz and 10 Hz square waves produced by the prescalers, together with a raw push-button and a mode selector. Emits a single-cycle `cpu_enable` pulse on `quick_clock` for each CPU step. The CPU register file and PC advance only on cycles where `cpu_enable` is high, so the whole design stays on one clock.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive `quick_clock` cycles the button must hold a new level before it is accepted; legal range ≥ 1.
- `quick_clock`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `slow_tick_1hz`  in  1  1 Hz square wave from a prescaler; asynchronous to this block's sampling.
- `slow_tick_10hz`  in  1  10 Hz square wave from a prescaler.
- `mode`  in  2  run mode, raw switch: 00 HALT, 01 RUN_SLOW (1 Hz), 10 RUN_FAST (10 Hz), 11 MANUAL.
- `step_button`  in  1  raw push-button, active high, bouncing, asynchronous.
- `cpu_enable`  out  1  one-cycle step pulse, registered.
- `step_count`  out  16  number of pulses issued since reset; see Configuration.

## Operation
- **Synchronizers.** `slow_tick_1hz`, `slow_tick_10hz`, `step_button` and both `mode` bits each pass through a 2-FF synchronizer (`*_s1`, `*_s2`).
- **Tick edges.** A third register per tick holds the previous `*_s2`. A tick edge is `s2 & ~prev`; only rising edges count.
- **Debouncer.**
  - Registers: `btn_state` and `db_cnt` (width `$clog2(DEBOUNCE_CYCLES)+1`).
  - If `btn_s2 == btn_state`: `db_cnt <= 0`.
  - Else if `db_cnt == DEBOUNCE_CYCLES-1`: `btn_state <= btn_s2` and `db_cnt <= 0`.
  - Else: `db_cnt <= db_cnt+1`.
  - A press event is a rising edge of `btn_state`, detected against `btn_prev`. Releases generate nothing.
- **Mode FSM.**
  - States HALT, RUN_SLOW, RUN_FAST, MANUAL, encoded as the `mode` values.
  - Every cycle, if `mode_s2 != state` then `state <= mode_s2`. `cpu_enable` is 0 in that cycle, and any event present in that cycle is dropped.
- **Event source by state (when the state is unchanged):**
  - HALT: none.
  - RUN_SLOW: 1 Hz edge.
  - RUN_FAST: 10 Hz edge.
  - MANUAL: press event.
- The debouncer runs in every state. A press outside MANUAL is discarded, not queued.
- **Settle guard.** A 2-bit `settle` counter clears on reset and saturates at 3. `cpu_enable` is forced to 0 while `settle != 3`. This suppresses false edges while the synchronizers fill after reset.
- `cpu_enable <= settle==3 && state unchanged && selected event`.

## Timing
- **Reset values (next edge with `reset`=1):**
  - All synchronizer, prev, `btn_state`, `btn_prev` and `db_cnt` registers: 0.
  - `state` = HALT, `settle` = 0.
  - `cpu_enable` = 0, `step_count` = 0.
- Reset mid-debounce or mid-pulse aborts it. No pulse is generated from pre-reset activity.
- **Tick latency.** A tick first sampled high at edge k gives `cpu_enable` high for exactly the cycle after edge k+2.
- **Button latency.** A clean button first sampled high at edge k:
  - `btn_state` rises at edge k+1+DEBOUNCE_CYCLES.
  - `cpu_enable` rises at edge k+2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES consecutive samples resets `db_cnt` and produces nothing.
- **Mode changes.** A new `mode` level sampled at edge k updates `state` at edge k+2. Events are honoured from edge k+3 onward.
- **Pulse rules.**
  - `cpu_enable` is never high for two consecutive cycles.
  - A held button yields exactly one pulse.
  - `step_count` increments at the same edge that sets `cpu_enable` and wraps 0xFFFF→0x0000.

## Configuration
- Macro: `CPU_STEP_COUNT_EN`.
- **Defined:** the 16-bit `step_count` register is built and behaves as in Timing.
- **Undefined:**
  - The port remains and is tied to 16'd0.
  - No counter logic is synthesized.
  - All other behaviour is identical.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and drive inputs between clock edges.

- **Reset hold.** `reset` held 5 cycles with all inputs high, mode=01, then released → `cpu_enable` stays 0 for the first 3 cycles; the first pulse occurs only after a fresh 0→1 on `slow_tick_1hz`.
- **RUN_SLOW.** mode=01, `slow_tick_1hz` toggled every 20 cycles for 3 rising edges → 3 pulses, each exactly 1 cycle wide, each 3 edges after its tick; `step_count`=3.
- **Bounce and glitch.**
  - Button pattern 1,0,1,0,1 (one cycle each), then held high 10 cycles, mode=11 → exactly 1 pulse, at edge k+6 after the stable high starts.
  - A later 3-cycle glitch → no pulse.
- **Wrong-mode source.** mode=10, slow_tick_1hz toggling, button pressed → pulses track only `slow_tick_10hz` edges; 1 Hz edges and the button produce none.
- **Mode switch drop.** A `mode` change 01→10 sampled at edge k, with a 1 Hz rising edge arriving so that its event lands at edge k+2 → no pulse at k+2; the next 10 Hz edge pulses normally.
- **Counter wrap (CPU_STEP_COUNT_EN defined).** Force `step_count`=0xFFFF, issue one pulse → `step_count`=0x0000. With the macro undefined → `step_count` constant 0.
